sc_digit_serial_adder: RTL
==========================

// Module: sc_digit_serial_adder
// PURPOSE
//   Parametrised digit-serial adder/subtractor for the SC datapath. Each cycle it adds one
//   DIGIT-bit slice of two WIDTH-bit operands, LSB slice first, through a chain of DIGIT
//   full-adder cells, and carries between slices in a carry flop. Gives area/latency
//   trade-off for PE binary post-processing. Uses valid/ready handshakes on input and output.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be >= 1
//   DIGIT  4   bits processed per cycle; 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0 (elaboration error otherwise)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operand set valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add mode only; ignored when sub=1)
//   sub        in   1      0: a+b+cin; 1: a-b (= a + ~b + 1)
//   out_valid  out  1      result valid (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result, two's-complement wrap modulo 2^WIDTH
//   cout       out  1      carry out of MSB; in sub mode 1 = no borrow (a >= b unsigned)
//   ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0,
//     internal operand/carry/count registers cleared. Reset mid-RUN or mid-DONE aborts the op;
//     no result is ever presented for an aborted op.
//   - N = WIDTH/DIGIT slices. FSM states IDLE, RUN, DONE:
//     IDLE: in_ready=1. On in_valid&in_ready edge: latch a, (sub ? ~b : b), carry flop <=
//       (sub ? 1 : cin), slice count <= 0. Go to RUN.
//     RUN: in_ready=0. Each edge adds slice k (bits k*DIGIT+DIGIT-1..k*DIGIT) plus carry flop,
//       writes DIGIT sum bits into the result register at slice k, updates carry flop, k++.
//       On the edge processing slice N-1: capture cout (carry out of bit WIDTH-1) and ovf
//       (carry into bit WIDTH-1 XOR cout), go to DONE.
//     DONE: out_valid=1; sum/cout/ovf stable. On out_valid&out_ready edge go to IDLE.
//       out_ready low holds DONE indefinitely with outputs unchanged.
//   - Latency: out_valid rises exactly N cycles after the accepting edge (DIGIT=WIDTH: 1 cycle).
//     Minimum throughput: one op per N+2 cycles (accept, N RUN edges, handshake edge).
//   - sum/cout/ovf may change during RUN; they are valid only while out_valid=1. They hold
//     their last values in IDLE until the next op overwrites them.
//   - in_ready and out_valid are never both high. in_valid during RUN/DONE is ignored
//     (operands not latched); inputs a/b/cin/sub need be stable only on the accepting edge.
//   - Combinational path per cycle is DIGIT full-adder cells (ripple); no other logic chained.
//   - out_ready asserted before DONE has no effect.
// TESTING (WIDTH=16, DIGIT=4 unless stated)
//   1. a=0xFFFF b=0x0001 cin=0 sub=0 -> out_valid 4 cycles after accept; sum=0x0000 cout=1 ovf=0.
//   2. a=0x0005 b=0x0007 sub=1 cin=1 (ignored) -> sum=0xFFFE cout=0 ovf=0; a=0x0007 b=0x0005 -> 0x0002 cout=1.
//   3. a=0x7FFF b=0x0001 add -> sum=0x8000 cout=0 ovf=1; a=0x8000 b=0x0001 sub -> 0x7FFF cout=1 ovf=1.
//   4. Backpressure: out_ready low 3 cycles in DONE -> sum/cout/ovf/out_valid stable, in_ready=0,
//      in_valid pulses ignored; out_ready high -> IDLE next edge, in_ready=1.
//   5. Assert rst 2 cycles after accept (mid-RUN) -> out_valid=0, sum=0, in_ready=1 immediately;
//      after release a=0x1234 b=0x4321 add -> sum=0x5555 cout=0 after 4 cycles.
//   6. Re-run 1-3 with DIGIT=1 (latency 16) and DIGIT=16 (latency 1) -> identical results;
//      plus 10k random ops vs reference model (a+b+cin / a-b) with random out_ready stalls.

Source files
------------

// File: rtl/sc_digit_serial_adder.sv
// rtl/sc_digit_serial_adder.sv - digit-serial adder/subtractor, DIGIT bits per cycle, LSB slice first
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   a, b, cin, sub        operands; sub=1 computes a-b and ignores cin
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   sum, cout, ovf        WIDTH-bit wrapped result, carry out of MSB, signed overflow

module sc_digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("sc_digit_serial_adder: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    // One slice of DIGIT ripple full-adder cells; c[i] is the carry into bit i of the slice.
    logic [DIGIT-1:0] slice_a, slice_b, slice_s;
    logic [DIGIT:0]   c;

    always_comb begin
        slice_a = a_q[cnt_q * DIGIT +: DIGIT];
        slice_b = b_q[cnt_q * DIGIT +: DIGIT];
        slice_s = '0;
        c       = '0;
        c[0]    = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            slice_s[i] = slice_a[i] ^ slice_b[i] ^ c[i];
            c[i+1]     = (slice_a[i] & slice_b[i]) | (c[i] & (slice_a[i] ^ slice_b[i]));
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1: invert b once here, seed the carry with 1.
                    a_d        = a;
                    b_d        = sub ? ~b : b;
                    carry_d    = sub ? 1'b1 : cin;
                    cnt_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                end
            end
            RUN: begin
                sum_d[cnt_q * DIGIT +: DIGIT] = slice_s;
                carry_d = c[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Top bit of the last slice is bit WIDTH-1, so c[DIGIT-1] is the carry into the MSB.
                    cout_d      = c[DIGIT];
                    ovf_d       = c[DIGIT-1] ^ c[DIGIT];
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
